// File: rtl/branch_predictor_if.sv
// Prediction/resolution bus between the RV32I pipeline (master) and the branch predictor (slave).
interface branch_predictor_if;
  logic        stall;
  logic [31:0] if_pc;
  logic        if_is_branch;
  logic [31:0] if_br_target;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        ex_is_branch;
  logic        ex_branch_take;
  logic [31:0] ex_pc;
  logic [31:0] ex_br_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  modport slave (
    input  stall,
    input  if_pc,
    input  if_is_branch,
    input  if_br_target,
    output pred_taken,
    output pred_pc,
    input  ex_is_branch,
    input  ex_branch_take,
    input  ex_pc,
    input  ex_br_target,
    output mispredict,
    output redirect_pc,
    output flush,
    output branch_cnt,
    output mispred_cnt
  );

  modport master (
    output stall,
    output if_pc,
    output if_is_branch,
    output if_br_target,
    input  pred_taken,
    input  pred_pc,
    output ex_is_branch,
    output ex_branch_take,
    output ex_pc,
    output ex_br_target,
    input  mispredict,
    input  redirect_pc,
    input  flush,
    input  branch_cnt,
    input  mispred_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal predictor: PC-indexed 2-bit saturating counters, prediction carried IF->ID->EX,
// resolved in EX against the comparator, with redirect/flush and resolution statistics.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16
) (
  input logic             clk,
  input logic             rst,
  branch_predictor_if.slave bp
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  if (ENTRIES < 4 || ENTRIES > 256 || (ENTRIES & (ENTRIES - 1)) != 0) begin : gen_bad_entries
    $error("branch_predictor: ENTRIES must be a power of two in 4..256");
  end

  logic [1:0]      ctr_q [ENTRIES];
  logic [1:0]      ctr_d [ENTRIES];
  logic            id_pred_q, id_pred_d;
  logic            ex_pred_q, ex_pred_d;
  logic [31:0]     branch_cnt_q, branch_cnt_d;
  logic [31:0]     mispred_cnt_q, mispred_cnt_d;

  logic [IdxW-1:0] if_idx;
  logic [IdxW-1:0] ex_idx;
  logic            pred_taken;
  logic            mispredict;
  logic            resolve;
  logic [1:0]      ex_ctr;
  logic [1:0]      ex_ctr_next;

  assign if_idx  = bp.if_pc[IdxW+1:2];
  assign ex_idx  = bp.ex_pc[IdxW+1:2];
  assign resolve = bp.ex_is_branch & ~bp.stall;

  // IF: table read sees the pre-update value even when EX writes the same index this cycle.
  always_comb begin
    pred_taken = bp.if_is_branch & ctr_q[if_idx][1];
    bp.pred_taken = pred_taken;
    bp.pred_pc    = pred_taken ? bp.if_br_target : bp.if_pc + 32'd4;
  end

  // EX: a predicted-taken bubble (not a branch) must also be undone.
  always_comb begin
    mispredict = 1'b0;
    if (!bp.stall) begin
      if (bp.ex_is_branch) begin
        mispredict = bp.ex_branch_take != ex_pred_q;
      end else begin
        mispredict = ex_pred_q;
      end
    end
    bp.mispredict  = mispredict;
    bp.flush       = mispredict;
    bp.redirect_pc = (mispredict & bp.ex_is_branch & bp.ex_branch_take) ? bp.ex_br_target
                                                                         : bp.ex_pc + 32'd4;
    bp.branch_cnt  = branch_cnt_q;
    bp.mispred_cnt = mispred_cnt_q;
  end

  // Saturating counter step for the resolving branch.
  always_comb begin
    ex_ctr      = ctr_q[ex_idx];
    ex_ctr_next = ex_ctr;
    if (bp.ex_branch_take) begin
      if (ex_ctr != 2'b11) begin
        ex_ctr_next = ex_ctr + 2'b01;
      end
    end else begin
      if (ex_ctr != 2'b00) begin
        ex_ctr_next = ex_ctr - 2'b01;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(ENTRIES); i++) begin
      ctr_d[i] = ctr_q[i];
    end
    if (resolve) begin
      ctr_d[ex_idx] = ex_ctr_next;
    end
  end

  always_comb begin
    id_pred_d = id_pred_q;
    ex_pred_d = ex_pred_q;
    if (!bp.stall) begin
      if (mispredict) begin
        id_pred_d = 1'b0;
        ex_pred_d = 1'b0;
      end else begin
        id_pred_d = pred_taken;
        ex_pred_d = id_pred_q;
      end
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (mispredict) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_q[i] <= 2'b01;
      end
      id_pred_q     <= 1'b0;
      ex_pred_q     <= 1'b0;
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_q[i] <= ctr_d[i];
      end
      id_pred_q     <= id_pred_d;
      ex_pred_q     <= ex_pred_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scenarios with literal expectations plus randomized traffic checked every cycle
// against a behavioural predictor model.
module tb_branch_predictor;

  localparam int unsigned Entries = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        if_is_branch = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic        ex_branch_take = 1'b0;
  logic [31:0] if_pc = 32'h0;
  logic [31:0] if_br_target = 32'h0;
  logic [31:0] ex_pc = 32'h0;
  logic [31:0] ex_br_target = 32'h0;
  logic        pred_taken, mispredict, flush;
  logic [31:0] pred_pc, redirect_pc, branch_cnt, mispred_cnt;

  int total = 0;
  int bad = 0;

  // Behavioural model state: counter values 0..3, prediction bits travelling IF->ID->EX.
  int          m_ctr [Entries];
  bit          m_id = 1'b0;
  bit          m_ex = 1'b0;
  logic [31:0] m_bc = 32'h0;
  logic [31:0] m_mc = 32'h0;

  branch_predictor_if bp_if ();

  assign bp_if.stall          = stall;
  assign bp_if.if_pc          = if_pc;
  assign bp_if.if_is_branch   = if_is_branch;
  assign bp_if.if_br_target   = if_br_target;
  assign bp_if.ex_is_branch   = ex_is_branch;
  assign bp_if.ex_branch_take = ex_branch_take;
  assign bp_if.ex_pc          = ex_pc;
  assign bp_if.ex_br_target   = ex_br_target;
  assign pred_taken  = bp_if.pred_taken;
  assign pred_pc     = bp_if.pred_pc;
  assign mispredict  = bp_if.mispredict;
  assign redirect_pc = bp_if.redirect_pc;
  assign flush       = bp_if.flush;
  assign branch_cnt  = bp_if.branch_cnt;
  assign mispred_cnt = bp_if.mispred_cnt;

  branch_predictor #(.ENTRIES(Entries)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pred();
    return (if_is_branch === 1'b1) && (m_ctr[(if_pc >> 2) % Entries] >= 2);
  endfunction

  function automatic bit m_mis();
    if (stall) return 1'b0;
    if (ex_is_branch) return ex_branch_take != m_ex;
    return m_ex;
  endfunction

  function automatic int sat_step(int c, bit up);
    if (up) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(Entries); i++) m_ctr[i] <= 1;
      m_id <= 1'b0;
      m_ex <= 1'b0;
      m_bc <= 32'h0;
      m_mc <= 32'h0;
    end else if (!stall) begin
      if (ex_is_branch) begin
        m_ctr[(ex_pc >> 2) % Entries] <= sat_step(m_ctr[(ex_pc >> 2) % Entries], ex_branch_take);
        m_bc <= m_bc + 32'd1;
      end
      if (m_mis()) begin
        m_mc <= m_mc + 32'd1;
        m_id <= 1'b0;
        m_ex <= 1'b0;
      end else begin
        m_id <= m_pred();
        m_ex <= m_id;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("pred_taken", {31'b0, pred_taken}, {31'b0, m_pred()});
      check("pred_pc", pred_pc, m_pred() ? if_br_target : if_pc + 32'd4);
      check("mispredict", {31'b0, mispredict}, {31'b0, m_mis()});
      check("flush", {31'b0, flush}, {31'b0, m_mis()});
      if (m_mis()) begin
        check("redirect_pc", redirect_pc,
              (ex_is_branch && ex_branch_take) ? ex_br_target : ex_pc + 32'd4);
      end
      check("branch_cnt", branch_cnt, m_bc);
      check("mispred_cnt", mispred_cnt, m_mc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall          = 1'b0;
    if_is_branch   = 1'b0;
    if_pc          = 32'h200;
    if_br_target   = 32'h0;
    ex_is_branch   = 1'b0;
    ex_branch_take = 1'b0;
    ex_pc          = 32'h300;
    ex_br_target   = 32'h0;
  endtask

  // Branch fetched in cycle 1, bubble in ID, resolved in EX in cycle 3 (after optional stalls).
  task automatic run_branch(input logic [31:0] pc, input logic [31:0] tgt, input bit take,
                            input bit is_br, input int stalls, input logic [31:0] if3_pc,
                            input bit if3_br, output bit p1, output logic [31:0] pp1,
                            output bit mis3, output logic [31:0] red3, output bit p3);
    idle();
    if_pc        = pc;
    if_is_branch = 1'b1;
    if_br_target = tgt;
    @(negedge clk);
    p1  = pred_taken;
    pp1 = pred_pc;
    cyc();
    idle();
    cyc();
    ex_is_branch   = is_br;
    ex_branch_take = take;
    ex_pc          = pc;
    ex_br_target   = tgt;
    if_pc          = if3_pc;
    if_is_branch   = if3_br;
    if_br_target   = if3_pc + 32'h40;
    for (int s = 0; s < stalls; s++) begin
      stall = 1'b1;
      @(negedge clk);
      check("stall_mispredict", {31'b0, mispredict}, 32'd0);
      check("stall_flush", {31'b0, flush}, 32'd0);
      cyc();
    end
    stall = 1'b0;
    @(negedge clk);
    mis3 = mispredict;
    red3 = redirect_pc;
    p3   = pred_taken;
    cyc();
    idle();
  endtask

  task automatic counts(input string tag, input logic [31:0] bc, input logic [31:0] mc);
    @(negedge clk);
    check({tag, "_branch_cnt"}, branch_cnt, bc);
    check({tag, "_mispred_cnt"}, mispred_cnt, mc);
    cyc();
  endtask

  bit          p1, mis3, p3;
  logic [31:0] pp1, red3;

  initial begin
    idle();
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    if_pc        = 32'h100;
    if_is_branch = 1'b1;
    if_br_target = 32'h140;
    @(negedge clk);
    check("reset_pred_taken", {31'b0, pred_taken}, 32'd0);
    check("reset_pred_pc", pred_pc, 32'h104);
    check("reset_branch_cnt", branch_cnt, 32'd0);
    check("reset_mispred_cnt", mispred_cnt, 32'd0);
    cyc();
    idle();
    cyc();

    // First-time taken: weak NT predicts not taken.
    run_branch(32'h100, 32'h140, 1'b1, 1'b1, 0, 32'h200, 1'b0, p1, pp1, mis3, red3, p3);
    check("first_p1", {31'b0, p1}, 32'd0);
    check("first_pp1", pp1, 32'h104);
    check("first_mis", {31'b0, mis3}, 32'd1);
    check("first_redirect", red3, 32'h140);
    counts("first", 32'd1, 32'd1);

    // Trained to weak T: predicted taken, resolves correctly.
    run_branch(32'h100, 32'h140, 1'b1, 1'b1, 0, 32'h200, 1'b0, p1, pp1, mis3, red3, p3);
    check("train_p1", {31'b0, p1}, 32'd1);
    check("train_pp1", pp1, 32'h140);
    check("train_mis", {31'b0, mis3}, 32'd0);
    run_branch(32'h100, 32'h140, 1'b1, 1'b1, 0, 32'h200, 1'b0, p1, pp1, mis3, red3, p3);
    check("sat_mis", {31'b0, mis3}, 32'd0);
    counts("train", 32'd3, 32'd1);

    // Predicted-taken slot that turns out not to be a branch.
    run_branch(32'h100, 32'h140, 1'b0, 1'b0, 0, 32'h200, 1'b0, p1, pp1, mis3, red3, p3);
    check("bubble_p1", {31'b0, p1}, 32'd1);
    check("bubble_mis", {31'b0, mis3}, 32'd1);
    check("bubble_redirect", red3, 32'h104);
    counts("bubble", 32'd3, 32'd2);

    // Not taken after strong taken: 11 -> 10, still predicts taken.
    run_branch(32'h100, 32'h140, 1'b0, 1'b1, 0, 32'h200, 1'b0, p1, pp1, mis3, red3, p3);
    check("nt_p1", {31'b0, p1}, 32'd1);
    check("nt_mis", {31'b0, mis3}, 32'd1);
    check("nt_redirect", red3, 32'h104);
    counts("nt", 32'd4, 32'd3);

    // Stalled resolution: exactly one update once the stall drops (10 -> 01).
    run_branch(32'h100, 32'h140, 1'b0, 1'b1, 3, 32'h200, 1'b0, p1, pp1, mis3, red3, p3);
    check("stall_p1", {31'b0, p1}, 32'd1);
    check("stall_release_mis", {31'b0, mis3}, 32'd1);
    check("stall_redirect", red3, 32'h104);
    counts("stall", 32'd5, 32'd4);

    // Same-index collision: 0x110 and 0x150 both map to index 4.
    run_branch(32'h110, 32'h180, 1'b1, 1'b1, 0, 32'h150, 1'b1, p1, pp1, mis3, red3, p3);
    check("coll_mis", {31'b0, mis3}, 32'd1);
    check("coll_redirect", red3, 32'h180);
    check("coll_old_pred", {31'b0, p3}, 32'd0);
    if_pc        = 32'h150;
    if_is_branch = 1'b1;
    if_br_target = 32'h190;
    @(negedge clk);
    check("coll_new_pred", {31'b0, pred_taken}, 32'd1);
    check("coll_new_pred_pc", pred_pc, 32'h190);
    cyc();
    idle();
    cyc();

    // Randomized traffic with stalls and occasional mid-run resets.
    for (int n = 0; n < 3000; n++) begin
      stall          = ($urandom_range(0, 7) == 0);
      if_is_branch   = $urandom_range(0, 1) == 1;
      if_pc          = 32'h1000 + ($urandom_range(0, 63) << 2);
      if_br_target   = $urandom;
      ex_is_branch   = $urandom_range(0, 2) != 0;
      ex_branch_take = $urandom_range(0, 1) == 1;
      ex_pc          = 32'h1000 + ($urandom_range(0, 63) << 2);
      ex_br_target   = $urandom;
      rst            = ($urandom_range(0, 499) != 0);
      cyc();
    end
    rst = 1'b1;
    idle();
    cyc();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor and resolution unit for the 5-stage RV32I pipeline.
- Predicts conditional branches in IF using a PC-indexed table of 2-bit saturating counters.
- Carries each prediction through ID to EX and checks it against the branch comparator's branch_take result.
- Updates the table and issues mispredict redirect/flush to the PC and pipeline-register logic.

Parameters:
ENTRIES  16  number of 2-bit counters in the table; power of two, 4..256
IDX_W  $clog2(ENTRIES)  table index width; index = pc[IDX_W+1:2]

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
stall  input  1  pipeline freeze; when 1 no internal state changes
if_pc  input  32  PC of instruction in IF
if_is_branch  input  1  IF predecode: instruction is a conditional branch (B-type)
if_br_target  input  32  if_pc + B-immediate, computed in IF
pred_taken  output  1  IF prediction: take branch
pred_pc  output  32  next fetch PC from predictor
ex_is_branch  input  1  EX holds a valid conditional branch (from decode)
ex_branch_take  input  1  branch comparator result for EX instruction
ex_pc  input  32  PC of EX instruction
ex_br_target  input  32  resolved branch target from EX adder
mispredict  output  1  EX prediction wrong; redirect this cycle
redirect_pc  output  32  correct next PC when mispredict=1
flush  output  1  kill IF/ID and ID/EX contents at next edge (= mispredict)
branch_cnt  output  32  resolved conditional branches since reset
mispred_cnt  output  32  mispredictions since reset

Behaviour:
- Reset (rst=0, asynchronous):
  - all counters = 2'b01 (weakly not-taken)
  - id_pred = ex_pred = 0
  - branch_cnt = mispred_cnt = 0
  - combinational outputs follow from this state: pred_taken=0, mispredict=0, flush=0
- Reset deasserted mid-operation: in-flight prediction bits are lost; behaviour restarts as from reset.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T; predict taken iff counter[1]=1.
- IF (combinational, 0-cycle latency):
  - pred_taken = if_is_branch & counter[if_pc[IDX_W+1:2]][1]
  - pred_pc = pred_taken ? if_br_target : if_pc+4 (32-bit wrap, no overflow flag)
- Prediction pipeline (two registers, id_pred then ex_pred), on each rising edge:
  - stall=1: hold both.
  - else if mispredict=1: id_pred <= 0, ex_pred <= 0 (flushed slots behave as bubbles).
  - else: id_pred <= pred_taken, ex_pred <= id_pred.
- Resolution in EX (combinational):
  - mispredict = ~stall & ((ex_is_branch & (ex_branch_take != ex_pred)) | (~ex_is_branch & ex_pred))
  - redirect_pc = (ex_is_branch & ex_branch_take) ? ex_br_target : ex_pc+4
  - redirect_pc is don't-care when mispredict=0; drive ex_pc+4 in that case for determinism.
  - flush = mispredict.
- Table update, at the edge when ex_is_branch=1 and stall=0:
  - index = ex_pc[IDX_W+1:2]
  - taken: counter increments, saturating at 11
  - not taken: counter decrements, saturating at 00
- Same-cycle read/write of one index (IF read, EX write): IF sees the old value; no bypass.
- Aliasing between PCs sharing an index is permitted and is not detected.
- Statistics, updated at the edge when ex_is_branch=1 and stall=0:
  - branch_cnt += 1
  - mispred_cnt += 1 when mispredict=1
  - both counters wrap modulo 2^32
- An ex_pred=1 bubble (ex_is_branch=0) redirects to ex_pc+4 and increments mispred_cnt only; branch_cnt is unchanged.
- Priority: rst > stall > mispredict flush > normal advance.

Test Plan:
- Reset check: rst=0, then release, if_pc=0x100, if_is_branch=1, if_br_target=0x140 -> pred_taken=0, pred_pc=0x104; both counters 0.
- First-time taken branch: branch at 0x100 reaches EX with ex_branch_take=1, ex_br_target=0x140 -> mispredict=1, redirect_pc=0x140, flush=1; id_pred/ex_pred cleared next edge; counter[0] 01->10; mispred_cnt=1.
- Training: same branch resolves taken again -> mispredict=0; counter 10->11, saturates at 11 on further taken; next IF of 0x100 gives pred_taken=1, pred_pc=0x140.
- Not-taken after strong-taken: counter=11, ex_branch_take=0, ex_pc=0x100 -> mispredict=1, redirect_pc=0x104, counter 11->10; prediction stays taken.
- Stall during resolution: mispredicting branch in EX with stall=1 for 3 cycles -> mispredict=0, counters/stats/pipeline bits unchanged; on the cycle stall drops, mispredict=1 and exactly one update occurs.
- Same-index collision: EX update to index 4 (ex_pc=0x110) in the same cycle IF reads 0x150 (also index 4, ENTRIES=16) -> IF prediction uses the pre-update counter; the following cycle uses the updated value.
